// File: rtl/rm14_encode.sv
// RM(1,4) systematic encoder: 5-bit message in, 16-bit codeword out in parallel
// and as a bit-serial stream with valid/ready flow control on both sides.
module rm14_encode #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  msg_in,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic [15:0] cw_out,
    output logic        cw_valid,
    output logic        tx_bit,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        busy
);

    // state | meaning
    // IDLE  | no codeword in flight, message port open
    // SEND  | shifting the loaded codeword out, one bit per tx transfer
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] shreg;
    logic [15:0] shreg_next;
    logic [15:0] cw_next;
    logic [3:0]  cnt;
    logic        accept;
    logic        xfer;

    // Affine Boolean function of the point x; the even-weight term carries m4.
    function automatic logic f_point(input logic [4:0] m, input logic [3:0] x);
        return ((^x) ? 1'b0 : m[4]) ^ (x[0] & m[3]) ^ (x[1] & m[2])
             ^ (x[2] & m[1]) ^ (x[3] & m[0]);
    endfunction

    // Information points 0,1,2,4,8 first so the message lands verbatim in [15:11].
    always_comb begin
        cw_next = {
            f_point(msg_in, 4'd0),  f_point(msg_in, 4'd1),
            f_point(msg_in, 4'd2),  f_point(msg_in, 4'd4),
            f_point(msg_in, 4'd8),  f_point(msg_in, 4'd3),
            f_point(msg_in, 4'd5),  f_point(msg_in, 4'd6),
            f_point(msg_in, 4'd7),  f_point(msg_in, 4'd9),
            f_point(msg_in, 4'd10), f_point(msg_in, 4'd11),
            f_point(msg_in, 4'd12), f_point(msg_in, 4'd13),
            f_point(msg_in, 4'd14), f_point(msg_in, 4'd15)
        };
    end

    always_comb begin
        shreg_next = MSB_FIRST ? {shreg[14:0], 1'b0} : {1'b0, shreg[15:1]};
    end

    assign tx_valid  = (state == SEND);
    assign busy      = (state == SEND);
    assign tx_last   = (state == SEND) && (cnt == 4'd15);
    assign tx_bit    = (state == SEND) && (MSB_FIRST ? shreg[15] : shreg[0]);
    assign xfer      = tx_valid & tx_ready;
    // Only combinational input-to-output path: lets a new message ride the last transfer.
    assign msg_ready = (state == IDLE) || (tx_last && tx_ready);
    assign accept    = msg_valid & msg_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            cw_out   <= '0;
            cnt      <= '0;
            cw_valid <= 1'b0;
        end else begin
            cw_valid <= accept;
            if (accept) begin
                shreg  <= cw_next;
                cw_out <= cw_next;
                cnt    <= '0;
                state  <= SEND;
            end else if (xfer) begin
                shreg <= shreg_next;
                cnt   <= cnt + 4'd1;
                if (cnt == 4'd15)
                    state <= IDLE;
            end
        end
    end

endmodule

// File: doc/rm14_encode.md
# rm14_encode

Systematic Reed-Muller RM(1,4) encoder: the transmit end of the RM(1,4) link.
- Accepts 5-bit messages on a valid/ready handshake and forms the 16-bit codeword with the message in bits [15:11] and 11 parity bits in [10:0], the layout the `decode` block consumes.
- Presents the codeword in parallel and streams it bit-serially to the channel/modulator over a second valid/ready handshake.
- Sustains one codeword per 16 cycles with back-to-back messages.

## Interface
Parameters:
- MSB_FIRST, 1, serial order: 1 = codeword bit 15 first, 0 = bit 0 first.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- msg_in  in  5  message m[4:0]; sampled on accept.
- msg_valid  in  1  message offered.
- msg_ready  out  1  encoder can accept; accept = msg_valid & msg_ready.
- cw_out  out  16  codeword of the most recently accepted message, held until the next accept.
- cw_valid  out  1  one-cycle pulse in the cycle after an accept.
- tx_bit  out  1  current serial codeword bit.
- tx_valid  out  1  tx_bit valid.
- tx_last  out  1  high with the 16th bit of a codeword.
- tx_ready  in  1  sink takes the bit; transfer = tx_valid & tx_ready.
- busy  out  1  high in SEND.

## Operation
Code definition (affine function f over points x = x3x2x1x0, 0..15):
- f(x) = (popcount(x) even ? m4 : 0) XOR (m3 if x0) XOR (m2 if x1) XOR (m1 if x2) XOR (m0 if x3).
- Information bits: cw[15]=f(0)=m4, cw[14]=f(1)=m3, cw[13]=f(2)=m2, cw[12]=f(4)=m1, cw[11]=f(8)=m0.
- Parity: cw[10-i] = f(q_i), q = 3,5,6,7,9,10,11,12,13,14,15 for i = 0..10.
- Every nonzero codeword has weight 8 or 16. Encoding is purely combinational from msg_in and registered on accept.

State machine: IDLE, SEND.
- IDLE: msg_ready=1, tx_valid=0. On accept: load shift register and cw_out, cnt<=0, go to SEND.
- SEND: tx_valid=1; tx_bit = shreg[15] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0); tx_last = (cnt==15).
- In SEND, each transfer shifts the register one place and increments cnt (4-bit). Without tx_ready, tx_bit, tx_last and cnt hold.
- Transfer with cnt==15: on a simultaneous accept, load the new codeword, set cnt<=0 and stay in SEND. Otherwise go to IDLE.
- msg_ready = IDLE | (SEND & cnt==15 & tx_ready). This is a combinational path from tx_ready; it is the only one.
- msg_valid with msg_ready low: no effect. The upstream holds msg_in.

## Timing
- Reset (rst_n low at an edge) returns the block to IDLE and clears shreg, cw_out, cnt and the outputs:
  - cw_out=0, cw_valid=0, tx_valid=0, tx_bit=0, tx_last=0, busy=0.
  - msg_ready=1 from the first cycle after reset release.
- Reset mid-stream abandons the codeword. No tx_last is produced for it.
- Accept at edge N:
  - cw_out updated and cw_valid=1 during cycle N+1.
  - First bit on tx_bit with tx_valid=1 in cycle N+1.
- With tx_ready held at 1, bits 1..16 occupy cycles N+1..N+16 and tx_last is high in cycle N+16.
- Back-to-back accept at edge N+16 gives the next first bit in N+17, with no bubble and tx_valid continuously high.
- tx_ready deasserted in cycle k: the same bit is presented in k+1. Stalls may occur on any bit, including the last.
- cw_valid pulses exactly once per accept, regardless of downstream stalls.

## Test plan
- Reset, then accept m=5'b00000 with tx_ready=1 -> cw_out=16'h0000; 16 zero bits; tx_last in the 16th cycle; then back to IDLE with msg_ready=1.
- m=5'b10000, MSB_FIRST=1 -> cw_out=16'h8769; serial stream 1000 0111 0110 1001.
- m=5'b01000 -> cw_out=16'h46D5; m=5'b11111 -> 16'hFFFF. Sweep all 32 messages: each cw_out[15:11]==m, weight is 0, 8 or 16, and each codeword is reproduced by a reference model of f.
- Back-to-back m=5'b10000 then 5'b01000 with msg_valid held, tx_ready=1 -> 32 contiguous bits 8769 then 46D5; second accept coincides with the first tx_last transfer; cw_valid pulses twice, 16 cycles apart.
- Random tx_ready stalls (~50%), including on bit 16 -> bit sequence unchanged; msg_ready stays 0 until the last bit transfers.
- rst_n low for one cycle at bit 7 of codeword 8769 -> all outputs 0 next cycle, IDLE, msg_ready=1; a following m=5'b01000 streams 46D5 in full.
